// File: rtl/pll_old_clkgen.sv
// pll_old_clkgen: counter-based stand-in for the pll_old vendor PLL wrapper.
// Define PLL_OLD_OUT_GATE_EN to hold clkout0/clkout1 low until lock is reached.
module pll_old_clkgen #(
    parameter int CLKOUT0_DIV = 2,
    parameter int CLKOUT1_DIV = 4,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic clkin1,
    input  logic rst_n,
    output logic clkout0,
    output logic clkout1,
    output logic lock
);

    if (CLKOUT0_DIV < 1 || CLKOUT0_DIV > 256) begin : g_bad_div0
        $error("pll_old_clkgen: CLKOUT0_DIV must be within 1..256");
    end
    if (CLKOUT1_DIV < 1 || CLKOUT1_DIV > 256) begin : g_bad_div1
        $error("pll_old_clkgen: CLKOUT1_DIV must be within 1..256");
    end
    if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_bad_lock
        $error("pll_old_clkgen: LOCK_CYCLES must be within 1..65535");
    end

    localparam int LW = $clog2(LOCK_CYCLES + 1);

    logic [1:0]    rst_sync;
    logic          run;
    logic [LW-1:0] lock_cnt;
    logic [LW-1:0] lock_cnt_nxt;
    logic          lock_q;
    logic          div_en;
    logic [1:0]    div_out;

    // Async assert, synchronous deassert: run rises on the 2nd edge after release.
    always_ff @(posedge clkin1 or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];

    always_comb begin
        lock_cnt_nxt = lock_cnt;
        if (run && (lock_cnt != LW'(LOCK_CYCLES))) begin
            lock_cnt_nxt = lock_cnt + LW'(1);
        end
    end

    always_ff @(posedge clkin1 or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            lock_q   <= 1'b0;
        end else begin
            lock_cnt <= lock_cnt_nxt;
            if (lock_cnt_nxt == LW'(LOCK_CYCLES)) begin
                lock_q <= 1'b1;
            end
        end
    end

`ifdef PLL_OLD_OUT_GATE_EN
    assign div_en = lock_q;
`else
    assign div_en = run;
`endif

    for (genvar i = 0; i < 2; i++) begin : g_div
        localparam int DIV = (i == 0) ? CLKOUT0_DIV : CLKOUT1_DIV;

        if (DIV == 1) begin : g_bypass
            logic en_n;

            // Enable changes only while clkin1 is low, so the AND gate cannot emit a runt.
            always_ff @(negedge clkin1 or negedge rst_n) begin
                if (!rst_n) begin
                    en_n <= 1'b0;
                end else begin
                    en_n <= div_en;
                end
            end

            assign div_out[i] = clkin1 & en_n;
        end else begin : g_count
            localparam int CW = $clog2(DIV);

            logic [CW-1:0] cnt;
            logic          q;

            always_ff @(posedge clkin1 or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                    q   <= 1'b0;
                end else if (div_en) begin
                    q   <= (cnt < CW'(DIV / 2));
                    cnt <= (cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
                end else begin
                    cnt <= '0;
                    q   <= 1'b0;
                end
            end

            assign div_out[i] = q;
        end
    end

    assign clkout0 = div_out[0];
    assign clkout1 = div_out[1];
    assign lock    = lock_q;

endmodule

// File: tb/tb_pll_old_clkgen.sv
// Directed bench for pll_old_clkgen: default, odd/bypass and long-lock instances.
// Expectations follow PLL_OLD_OUT_GATE_EN when the bench is built with it defined.
module tb_pll_old_clkgen;

`ifdef PLL_OLD_OUT_GATE_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    logic clkin1 = 1'b0;
    logic rst_n_a = 1'b0;
    logic rst_n_b = 1'b0;
    logic rst_n_c = 1'b0;
    logic clkout0_a, clkout1_a, lock_a;
    logic clkout0_b, clkout1_b, lock_b;
    logic clkout0_c, clkout1_c, lock_c;

    int tests_run    = 0;
    int tests_failed = 0;
    int k_a          = 0;

    always #10 clkin1 = ~clkin1;

    pll_old_clkgen #(.CLKOUT0_DIV(2), .CLKOUT1_DIV(4), .LOCK_CYCLES(1024)) dut_a (
        .clkin1(clkin1), .rst_n(rst_n_a),
        .clkout0(clkout0_a), .clkout1(clkout1_a), .lock(lock_a)
    );

    pll_old_clkgen #(.CLKOUT0_DIV(3), .CLKOUT1_DIV(1), .LOCK_CYCLES(4)) dut_b (
        .clkin1(clkin1), .rst_n(rst_n_b),
        .clkout0(clkout0_b), .clkout1(clkout1_b), .lock(lock_b)
    );

    pll_old_clkgen #(.CLKOUT0_DIV(2), .CLKOUT1_DIV(4), .LOCK_CYCLES(65535)) dut_c (
        .clkin1(clkin1), .rst_n(rst_n_c),
        .clkout0(clkout0_c), .clkout1(clkout1_c), .lock(lock_c)
    );

    // Last rising edge (counted from reset release) on which the dividers are still idle.
    function automatic int en_edge(input int lock_cycles);
        return GATED ? lock_cycles + 2 : 2;
    endfunction

    // Divider output just after rising edge k: high for the first n/2 of every n edges.
    function automatic logic exp_div(input int k, input int n, input int e);
        if (k <= e) return 1'b0;
        return ((k - e - 1) % n) < (n / 2);
    endfunction

    task automatic test_reset;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        rst_n_c = 1'b0;
        #45;
        tests_run++;
        if ({lock_a, clkout0_a, clkout1_a} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_a: got %b expected 000", {lock_a, clkout0_a, clkout1_a});
        end
        tests_run++;
        if ({lock_b, clkout0_b, clkout1_b} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_b: got %b expected 000", {lock_b, clkout0_b, clkout1_b});
        end
        tests_run++;
        if ({lock_c, clkout0_c, clkout1_c} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_c: got %b expected 000", {lock_c, clkout0_c, clkout1_c});
        end
    endtask

    task automatic test_lock_timing;
        int   first = 0;
        int   falls = 0;
        logic prev  = 1'b0;
        int   e     = en_edge(1024);
        @(negedge clkin1);
        #5 rst_n_a = 1'b1;
        k_a = 0;
        while ($time < 50000 && k_a < 4000) begin
            @(posedge clkin1);
            #1;
            k_a++;
            if (lock_a === 1'b1 && first == 0) first = k_a;
            if (prev === 1'b1 && lock_a !== 1'b1) falls++;
            prev = lock_a;
            if (k_a <= 8) begin
                tests_run++;
                if ({clkout0_a, clkout1_a} !== {exp_div(k_a, 2, e), exp_div(k_a, 4, e)}) begin
                    tests_failed++;
                    $display("FAIL startup_a edge %0d: got %b expected %b", k_a,
                             {clkout0_a, clkout1_a}, {exp_div(k_a, 2, e), exp_div(k_a, 4, e)});
                end
            end
        end
        tests_run++;
        if (first != 1026) begin
            tests_failed++;
            $display("FAIL lock_edge_a: got %0d expected 1026", first);
        end
        tests_run++;
        if (falls != 0) begin
            tests_failed++;
            $display("FAIL lock_sticky_a: got %0d falls expected 0", falls);
        end
        tests_run++;
        if (lock_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL lock_50us_a: got %b expected 1", lock_a);
        end
    endtask

    task automatic test_freq;
        int e = en_edge(1024);
        for (int i = 0; i < 16; i++) begin
            @(posedge clkin1);
            #1;
            k_a++;
            tests_run++;
            if ({clkout0_a, clkout1_a} !== {exp_div(k_a, 2, e), exp_div(k_a, 4, e)}) begin
                tests_failed++;
                $display("FAIL freq_rise edge %0d: got %b expected %b", k_a,
                         {clkout0_a, clkout1_a}, {exp_div(k_a, 2, e), exp_div(k_a, 4, e)});
            end
            @(negedge clkin1);
            #1;
            tests_run++;
            if ({clkout0_a, clkout1_a} !== {exp_div(k_a, 2, e), exp_div(k_a, 4, e)}) begin
                tests_failed++;
                $display("FAIL freq_fall edge %0d: got %b expected %b", k_a,
                         {clkout0_a, clkout1_a}, {exp_div(k_a, 2, e), exp_div(k_a, 4, e)});
            end
        end
    endtask

    task automatic test_mid_reset;
        int first = 0;
        int e     = en_edge(1024);
        @(posedge clkin1);
        #3 rst_n_a = 1'b0;
        #1;
        tests_run++;
        if ({lock_a, clkout0_a, clkout1_a} !== 3'b000) begin
            tests_failed++;
            $display("FAIL midreset_async: got %b expected 000", {lock_a, clkout0_a, clkout1_a});
        end
        #4 rst_n_a = 1'b1;
        k_a = 0;
        while (first == 0 && k_a < 1100) begin
            @(posedge clkin1);
            #1;
            k_a++;
            if (lock_a === 1'b1) first = k_a;
            if (k_a <= 4) begin
                tests_run++;
                if (clkout0_a !== exp_div(k_a, 2, e)) begin
                    tests_failed++;
                    $display("FAIL restart_clkout0 edge %0d: got %b expected %b", k_a,
                             clkout0_a, exp_div(k_a, 2, e));
                end
            end
        end
        tests_run++;
        if (first != 1026) begin
            tests_failed++;
            $display("FAIL relock_edge: got %0d expected 1026", first);
        end
    endtask

    task automatic test_odd_bypass;
        int e = en_edge(4);
        @(negedge clkin1);
        #5 rst_n_b = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clkin1);
            #1;
            tests_run++;
            if ({lock_b, clkout0_b, clkout1_b} !==
                {(k >= 6) ? 1'b1 : 1'b0, exp_div(k, 3, e), (k > e) ? 1'b1 : 1'b0}) begin
                tests_failed++;
                $display("FAIL odd_high edge %0d: got %b expected %b", k,
                         {lock_b, clkout0_b, clkout1_b},
                         {(k >= 6) ? 1'b1 : 1'b0, exp_div(k, 3, e), (k > e) ? 1'b1 : 1'b0});
            end
            @(negedge clkin1);
            #1;
            tests_run++;
            if ({clkout0_b, clkout1_b} !== {exp_div(k, 3, e), 1'b0}) begin
                tests_failed++;
                $display("FAIL odd_low edge %0d: got %b expected %b", k,
                         {clkout0_b, clkout1_b}, {exp_div(k, 3, e), 1'b0});
            end
        end
    endtask

    task automatic test_saturation;
        int   first = 0;
        int   rises = 0;
        int   falls = 0;
        logic prev  = 1'b0;
        @(negedge clkin1);
        #5 rst_n_c = 1'b1;
        for (int k = 1; k <= 70000; k++) begin
            @(posedge clkin1);
            #1;
            if (lock_c === 1'b1 && first == 0) first = k;
            if (prev !== 1'b1 && lock_c === 1'b1) rises++;
            if (prev === 1'b1 && lock_c !== 1'b1) falls++;
            prev = lock_c;
        end
        tests_run++;
        if (first != 65537) begin
            tests_failed++;
            $display("FAIL sat_lock_edge: got %0d expected 65537", first);
        end
        tests_run++;
        if (rises != 1 || falls != 0) begin
            tests_failed++;
            $display("FAIL sat_once: got rises=%0d falls=%0d expected rises=1 falls=0", rises, falls);
        end
        tests_run++;
        if (lock_c !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_final: got %b expected 1", lock_c);
        end
    endtask

    initial begin
        test_reset();
        test_lock_timing();
        test_freq();
        test_mid_reset();
        test_odd_bypass();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
